jogo_sequencia_param: RTL

Parametrised sequence-memory game unit, successor to the Experiment 4 control-unit circuit. It compares successive player moves on `chaves` against an internal sequence ROM and ends each game in one of three held outcomes: hit, miss or timeout. It adds three things the earlier circuit lacks: a configurable key width, a configurable sequence depth, and a move timeout. It sits between the board switch/button inputs and the 7-segment/LED debug logic.

---
 rtl/jogo_sequencia_param_pkg.sv | 26 ++
 rtl/jogo_sequencia_param_detector_jogada.sv | 36 +++
 rtl/jogo_sequencia_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/jogo_sequencia_param_pkg.sv
// ---------------------------------------------------------------------------
// jogo_sequencia_param_pkg
// Shared definitions for the sequence-memory game: the FSM state codes and a
// helper that tells whether a state is one of the terminal outcome states.
// The numeric codes are fixed because they are shown on the 7-segment debug
// display and decoded by other blocks, so the enum values are explicit.
// ---------------------------------------------------------------------------
package jogo_sequencia_param_pkg;

  typedef enum logic [3:0] {
    inicial     = 4'h0,
    preparacao  = 4'h1,
    espera      = 4'h2,
    compara     = 4'h3,
    proximo     = 4'h4,
    fim_acertou = 4'hA,
    fim_errou   = 4'hE,
    fim_timeout = 4'hC
  } estado_t;

  // True for the three held outcome states, which all raise "pronto".
  function automatic logic estado_final(input estado_t e);
    return (e == fim_acertou) || (e == fim_errou) || (e == fim_timeout);
  endfunction

endpackage

// File: rtl/jogo_sequencia_param_detector_jogada.sv
// ---------------------------------------------------------------------------
// detector_jogada
// Turns the raw button vector into a one-cycle "move" strobe. A move is the
// transition from no button pressed to at least one button pressed, so a
// button that stays held produces only a single strobe.
//
// Ports:
//   clock   in  1  system clock, rising edge
//   reset   in  1  asynchronous, active-high; clears the previous sample
//   chaves  in  N  player buttons
//   jogada  out 1  high while chaves is nonzero and the previous sample was zero
// ---------------------------------------------------------------------------
module detector_jogada #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] chaves,
  output logic         jogada
);

  logic [N-1:0] chaves_ant;

  // Previous-cycle copy of the buttons, sampled unconditionally every clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chaves_ant <= '0;
    end else begin
      chaves_ant <= chaves;
    end
  end

  // Rising edge of "any button pressed".
  assign jogada = (|chaves) & ~(|chaves_ant);

endmodule

// File: rtl/jogo_sequencia_param.sv
// ---------------------------------------------------------------------------
// jogo_sequencia_param
// Sequence-memory game unit. The player must press, one move at a time, the
// words stored in a fixed ROM (word[i] = 1 << (i mod N)). The game ends in a
// held outcome: full sequence matched, a wrong move, or a move deadline miss.
//
// Parameters:
//   N               key width (number of buttons), >= 2
//   DEPTH           sequence length, >= 2
//   TIMEOUT_CICLOS  cycles allowed per move, 0 disables the deadline
//
// Ports:
//   clock        in  1   system clock, rising edge
//   reset        in  1   asynchronous, active-high; returns to "inicial"
//   iniciar      in  1   start/restart a game (only honoured when idle/finished)
//   chaves       in  N   player buttons
//   pronto       out 1   game finished
//   acertou      out 1   full sequence matched
//   errou        out 1   a move mismatched
//   timeout      out 1   move deadline expired
//   db_igual     out 1   registered move equals current ROM word
//   db_iniciar   out 1   copy of iniciar
//   db_contagem  out AW  current sequence address
//   db_memoria   out N   ROM word at the current address
//   db_jogada    out N   last registered move
//   db_estado    out 4   state code
// ---------------------------------------------------------------------------
module jogo_sequencia_param
  import jogo_sequencia_param_pkg::*;
#(
  parameter  int N              = 4,
  parameter  int DEPTH          = 16,
  parameter  int TIMEOUT_CICLOS = 5000,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic [N-1:0]  chaves,
  output logic          pronto,
  output logic          acertou,
  output logic          errou,
  output logic          timeout,
  output logic          db_igual,
  output logic          db_iniciar,
  output logic [AW-1:0] db_contagem,
  output logic [N-1:0]  db_memoria,
  output logic [N-1:0]  db_jogada,
  output logic [3:0]    db_estado
);

  // The deadline counter only has to reach TIMEOUT_CICLOS-1.
  localparam int            CW          = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam bit            TEMPO_ATIVO = (TIMEOUT_CICLOS != 0);
  localparam logic [CW-1:0] LIMITE      = CW'((TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0);

  // Sequence ROM: a single walking one that repeats every N addresses.
  function automatic logic [N-1:0] rom_palavra(input logic [AW-1:0] endereco);
    int indice;
    indice = int'(endereco) % N;
    return N'(1) << indice;
  endfunction

  estado_t       estado;
  estado_t       proximo_estado;
  logic [AW-1:0] contagem;
  logic [CW-1:0] contador_tempo;
  logic [N-1:0]  jogada_reg;
  logic [N-1:0]  palavra;
  logic          jogada;
  logic          igual;
  logic          tempo_esgotado;
  logic          ultimo_endereco;

  detector_jogada #(
    .N(N)
  ) u_detector (
    .clock  (clock),
    .reset  (reset),
    .chaves (chaves),
    .jogada (jogada)
  );

  assign palavra         = rom_palavra(contagem);
  assign igual           = (jogada_reg == palavra);
  assign tempo_esgotado  = TEMPO_ATIVO && (contador_tempo == LIMITE);
  assign ultimo_endereco = (contagem == AW'(DEPTH - 1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= inicial;
    end else begin
      estado <= proximo_estado;
    end
  end

  // Next-state logic. In "espera" a move takes priority over the deadline,
  // and "iniciar" is only looked at while idle or finished.
  always_comb begin
    proximo_estado = estado;
    case (estado)
      inicial: begin
        if (iniciar) proximo_estado = preparacao;
      end
      preparacao: begin
        proximo_estado = espera;
      end
      espera: begin
        if (jogada) begin
          proximo_estado = compara;
        end else if (tempo_esgotado) begin
          proximo_estado = fim_timeout;
        end
      end
      compara: begin
        if (!igual) begin
          proximo_estado = fim_errou;
        end else if (ultimo_endereco) begin
          proximo_estado = fim_acertou;
        end else begin
          proximo_estado = proximo;
        end
      end
      proximo: begin
        proximo_estado = espera;
      end
      fim_acertou, fim_errou, fim_timeout: begin
        if (iniciar) proximo_estado = preparacao;
      end
      default: begin
        proximo_estado = inicial;
      end
    endcase
  end

  // Datapath: sequence address, per-move deadline counter and move register.
  // The address only advances after a match that is not the last word, so it
  // never wraps past DEPTH-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem       <= '0;
      contador_tempo <= '0;
      jogada_reg     <= '0;
    end else begin
      case (estado)
        preparacao: begin
          contagem       <= '0;
          contador_tempo <= '0;
          jogada_reg     <= '0;
        end
        espera: begin
          if (jogada) begin
            jogada_reg <= chaves;
          end else if (TEMPO_ATIVO && !tempo_esgotado) begin
            contador_tempo <= contador_tempo + CW'(1);
          end
        end
        proximo: begin
          contagem       <= contagem + AW'(1);
          contador_tempo <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs. The ROM/compare debug outputs are forced low in "inicial"
  // so that the whole output set reads zero after reset.
  always_comb begin
    pronto     = estado_final(estado);
    acertou    = (estado == fim_acertou);
    errou      = (estado == fim_errou);
    timeout    = (estado == fim_timeout);
    db_igual   = (estado != inicial) && igual;
    db_memoria = (estado == inicial) ? '0 : palavra;
  end

  assign db_iniciar  = iniciar;
  assign db_contagem = contagem;
  assign db_jogada   = jogada_reg;
  assign db_estado   = estado;

endmodule
